// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared types and defaults for the shift-register sequencer
package usr_pkg;

  localparam int USR_WIDTH = 4;
  localparam int USR_CNT_W = 4;
  localparam int USR_SER_W = 16;

  // sel driven to the shift register is numerically equal to the op code
  typedef enum logic [1:0] {
    OP_HOLD    = 2'b00,
    OP_SHIFT_A = 2'b01,
    OP_SHIFT_R = 2'b10,
    OP_LOAD    = 2'b11
  } usr_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } usr_state_e;

endpackage

// File: rtl/usr_shift_sequencer_if.sv
// rtl/usr_shift_sequencer_if.sv - command handshake and shift-register drive bundle
interface usr_shift_sequencer_if
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH,
  parameter int CNT_W = USR_CNT_W,
  parameter int SER_W = USR_SER_W
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic [SER_W-1:0] cmd_serial;
  logic [1:0]       sel;
  logic [WIDTH-1:0] inp;
  logic             serial_in;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_serial,
    input  cmd_ready, sel, inp, serial_in, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_serial,
    output cmd_ready, sel, inp, serial_in, busy, done
  );

endinterface

// File: rtl/usr_bit_source.sv
// rtl/usr_bit_source.sv - serial shadow word presenting its LSB as the next serial bit
module usr_bit_source
  import usr_pkg::*;
#(
  parameter int SER_W = USR_SER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [SER_W-1:0] i_word,
  input  logic             i_shift,
  input  logic             i_clear,
  output logic             o_bit
);

  logic [SER_W-1:0] r_shadow;

  // Clearing on exit keeps the bit at 0 outside a shift run even if unused bits remain
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_shadow <= '0;
    end else if (i_load) begin
      r_shadow <= i_word;
    end else if (i_shift) begin
      r_shadow <= r_shadow >> 1;
    end
  end

  assign o_bit = r_shadow[0];

endmodule

// File: rtl/usr_shift_sequencer.sv
// rtl/usr_shift_sequencer.sv - sequences load/hold/shift commands onto a universal shift register
module usr_shift_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH,
  parameter int CNT_W = USR_CNT_W,
  parameter int SER_W = USR_SER_W
) (
  input  logic                  clk,
  input  logic                  reset,
  usr_shift_sequencer_if.slave  bus
);

  usr_state_e       r_state;
  usr_state_e       w_next;
  logic [1:0]       r_op;
  logic [1:0]       w_op_n;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_n;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_n;
  logic [1:0]       r_sel;
  logic [1:0]       w_sel_n;
  logic [WIDTH-1:0] r_inp;
  logic [WIDTH-1:0] w_inp_n;
  logic             r_busy;
  logic             w_busy_n;
  logic             r_done;
  logic             w_done_n;
  logic             w_accept;
  logic             w_src_load;
  logic             w_src_shift;
  logic             w_src_clear;
  logic             w_serial_bit;

  assign bus.cmd_ready = (r_state == IDLE) && !reset;
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    w_next      = r_state;
    w_op_n      = r_op;
    w_data_n    = r_data;
    w_count_n   = r_count;
    w_src_load  = 1'b0;
    w_src_shift = 1'b0;
    w_src_clear = 1'b0;
    w_sel_n     = OP_HOLD;
    w_inp_n     = '0;
    w_busy_n    = 1'b0;
    w_done_n    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_op_n    = bus.cmd_op;
          w_data_n  = bus.cmd_data;
          w_count_n = bus.cmd_count;
          if (bus.cmd_op == OP_LOAD) begin
            w_next = LOAD;
          end else if (bus.cmd_count != '0) begin
            w_next     = RUN;
            w_src_load = 1'b1;
          end else begin
            w_next = DONE;
          end
        end
      end
      LOAD: w_next = DONE;
      RUN: begin
        // The count saturates at 0 so the run length is exactly the accepted count
        if (r_count <= CNT_W'(1)) begin
          w_next      = DONE;
          w_count_n   = '0;
          w_src_clear = 1'b1;
        end else begin
          w_count_n   = r_count - 1'b1;
          w_src_shift = 1'b1;
        end
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase

    // Outputs are registered from the state being entered, so they line up with it
    case (w_next)
      LOAD: begin
        w_sel_n  = OP_LOAD;
        w_inp_n  = w_data_n;
        w_busy_n = 1'b1;
      end
      RUN: begin
        w_sel_n  = w_op_n;
        w_busy_n = 1'b1;
      end
      DONE: begin
        w_busy_n = 1'b1;
        w_done_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= OP_HOLD;
      r_data  <= '0;
      r_count <= '0;
      r_sel   <= OP_HOLD;
      r_inp   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_op    <= w_op_n;
      r_data  <= w_data_n;
      r_count <= w_count_n;
      r_sel   <= w_sel_n;
      r_inp   <= w_inp_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  usr_bit_source #(
    .SER_W (SER_W)
  ) u_bit_source (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_src_load),
    .i_word  (bus.cmd_serial),
    .i_shift (w_src_shift),
    .i_clear (w_src_clear),
    .o_bit   (w_serial_bit)
  );

  assign bus.sel       = r_sel;
  assign bus.inp       = r_inp;
  assign bus.serial_in = w_serial_bit;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
